pattern_scan_ctrl: RTL and testbench

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

---
 rtl/pattern_scan_ctrl_if.sv | 30 +++
 rtl/pattern_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pattern_scan_ctrl_if.sv
// Control/data bundle for pattern_scan_ctrl: scan request, frozen-at-start
// configuration, serial input and match/status outputs.
interface pattern_scan_ctrl_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) ();
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] cfg_pattern;
  logic             cfg_overlap;
  logic [WIN_W-1:0] cfg_window;
  logic             din;
  logic             din_valid;
  logic             busy;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             overflow;
  logic             done;

  modport master (
    output start, abort, cfg_pattern, cfg_overlap, cfg_window, din, din_valid,
    input  busy, match, match_count, overflow, done
  );

  modport slave (
    input  start, abort, cfg_pattern, cfg_overlap, cfg_window, din, din_valid,
    output busy, match, match_count, overflow, done
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Serial pattern scanner: counts occurrences of a PAT_W-bit pattern within a
// window of valid bits, with overlap control, saturation and abort.
module pattern_scan_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input logic                clk,
  input logic                reset,
  pattern_scan_ctrl_if.slave bus
);

  localparam int                FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             ovl_q, ovl_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [WIN_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             run_s;
  logic             accept_s;
  logic             hit_s;
  logic             match_s;
  logic [PAT_W-1:0] shifted_s;
  logic [WIN_W-1:0] bits_inc_s;

  // The pattern is compared against the history plus the bit on the wire, so
  // the strobe fires in the same cycle as the final pattern bit.
  assign shifted_s  = {hist_q, bus.din};
  assign hit_s      = (fill_q == FILL_MAX) && (shifted_s == pat_q);
  assign run_s      = (state_q == S_RUN);
  assign accept_s   = run_s && bus.din_valid && !bus.abort && (win_q != '0);
  assign match_s    = accept_s && hit_s;
  assign bits_inc_s = bits_q + WIN_W'(1);

  // Next-state logic for the FSM, shadow config, history and counters.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    win_d   = win_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    bits_d  = bits_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pat_d   = bus.cfg_pattern;
          ovl_d   = bus.cfg_overlap;
          win_d   = bus.cfg_window;
          hist_d  = '0;
          fill_d  = '0;
          bits_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (win_q == '0) begin
          state_d = S_DONE;
        end else if (bus.din_valid) begin
          hist_d = shifted_s[PAT_W-2:0];
          bits_d = bits_inc_s;
          // Non-overlapping mode restarts the fill so no bit is reused.
          if (match_s && !ovl_q) begin
            fill_d = '0;
          end else if (fill_q != FILL_MAX) begin
            fill_d = fill_q + FILL_W'(1);
          end else begin
            fill_d = fill_q;
          end
          if (match_s) begin
            if (cnt_q == '1) begin
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
          if (bits_inc_s == win_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      win_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      bits_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      win_q   <= win_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy        = run_s;
  assign bus.done        = (state_q == S_DONE);
  assign bus.match       = match_s;
  assign bus.match_count = cnt_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench: two instances (8-bit and 2-bit counters) share one
// stimulus stream and are compared against a windowed-search reference model.
module tb_pattern_scan_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] cfg_pattern;
  logic       cfg_overlap;
  logic [7:0] cfg_window;
  logic       din;
  logic       din_valid;

  int checks = 0;
  int errors = 0;

  bit sbits [32];
  bit exp_m [32];
  int exp_cum [32];

  pattern_scan_ctrl_if #(.PAT_W(4), .CNT_W(8), .WIN_W(8)) ifa ();
  pattern_scan_ctrl_if #(.PAT_W(4), .CNT_W(2), .WIN_W(8)) ifs ();

  assign ifa.start = start;       assign ifs.start = start;
  assign ifa.abort = abort;       assign ifs.abort = abort;
  assign ifa.cfg_pattern = cfg_pattern; assign ifs.cfg_pattern = cfg_pattern;
  assign ifa.cfg_overlap = cfg_overlap; assign ifs.cfg_overlap = cfg_overlap;
  assign ifa.cfg_window = cfg_window;   assign ifs.cfg_window = cfg_window;
  assign ifa.din = din;           assign ifs.din = din;
  assign ifa.din_valid = din_valid; assign ifs.din_valid = din_valid;

  pattern_scan_ctrl #(.PAT_W(4), .CNT_W(8), .WIN_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  pattern_scan_ctrl #(.PAT_W(4), .CNT_W(2), .WIN_W(8)) dut_s (
    .clk(clk), .reset(reset), .bus(ifs.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(input int m, input int cw);
    int mx;
    mx = (1 << cw) - 1;
    return (m > mx) ? mx : m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare status outputs of both instances given the true number of matches.
  task automatic check_state(input string tag, input bit eb, input bit ed, input int m);
    chk({tag, ".busy"}, 32'(ifa.busy), 32'(eb));
    chk({tag, ".done"}, 32'(ifa.done), 32'(ed));
    chk({tag, ".cnt8"}, 32'(ifa.match_count), 32'(sat(m, 8)));
    chk({tag, ".ovf8"}, 32'(ifa.overflow), 32'(m > 255));
    chk({tag, ".cnt2"}, 32'(ifs.match_count), 32'(sat(m, 2)));
    chk({tag, ".ovf2"}, 32'(ifs.overflow), 32'(m > 3));
    chk({tag, ".busy2"}, 32'(ifs.busy), 32'(eb));
    chk({tag, ".done2"}, 32'(ifs.done), 32'(ed));
  endtask

  task automatic chk_match(input string tag, input bit e);
    chk({tag, ".match8"}, 32'(ifa.match), 32'(e));
    chk({tag, ".match2"}, 32'(ifs.match), 32'(e));
  endtask

  // Reference: a match ends at bit k when the last four accepted bits equal
  // the pattern and, without overlap, none of them belongs to an earlier match.
  task automatic model_scan(input logic [3:0] pat, input bit ovl, input int win);
    int last;
    int m;
    bit ok;
    last = -100;
    m = 0;
    for (int k = 0; k < win; k++) begin
      exp_m[k] = 1'b0;
      if (k >= 3) begin
        ok = 1'b1;
        for (int j = 0; j < 4; j++) begin
          if (sbits[k - 3 + j] != pat[3 - j]) ok = 1'b0;
        end
        if (ok && (ovl || (k - 3 > last))) begin
          exp_m[k] = 1'b1;
          m++;
          last = k;
        end
      end
      exp_cum[k] = m;
    end
  endtask

  task automatic load_stream10();
    logic [9:0] s;
    s = 10'b1011011011;
    for (int i = 0; i < 10; i++) sbits[i] = s[9 - i];
  endtask

  task automatic do_scan(input logic [3:0] pat, input bit ovl, input int win, input bit gaps,
                         input int abort_at, input bit cfg_chg, input bit start_in_run);
    int k;
    int na;
    int ng;
    bit ab;
    model_scan(pat, ovl, win);
    @(negedge clk);
    cfg_pattern = pat; cfg_overlap = ovl; cfg_window = 8'(win);
    start = 1'b1; abort = 1'b0; din_valid = 1'b0; din = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_state("start", 1'b1, 1'b0, 0);
    if (win == 0) begin
      start = start_in_run; din = 1'b1; din_valid = 1'b1;
      #1 chk_match("win0", 1'b0);
      @(negedge clk);
      start = 1'b0; din_valid = 1'b0;
    end
    k = 0;
    while (k < win) begin
      if (cfg_chg) begin
        cfg_pattern = 4'($urandom); cfg_overlap = 1'($urandom); cfg_window = 8'($urandom);
      end
      if (gaps && $urandom_range(0, 2) == 0) begin
        ng = $urandom_range(1, 3);
        for (int g = 0; g < ng; g++) begin
          din_valid = 1'b0; din = 1'($urandom);
          if (cfg_chg) cfg_pattern = 4'($urandom);
          #1 chk_match("gap", 1'b0);
          @(negedge clk);
        end
      end
      ab = (k == abort_at);
      din = sbits[k]; din_valid = 1'b1; abort = ab;
      start = start_in_run && (k == 0);
      #1 chk_match($sformatf("bit%0d", k), ab ? 1'b0 : exp_m[k]);
      @(negedge clk);
      start = 1'b0; din_valid = 1'b0; abort = 1'b0;
      if (ab) begin
        na = (k > 0) ? exp_cum[k - 1] : 0;
        check_state("abort", 1'b0, 1'b0, na);
        @(negedge clk);
        check_state("abort_idle", 1'b0, 1'b0, na);
        return;
      end
      k++;
    end
    na = (win > 0) ? exp_cum[win - 1] : 0;
    check_state("done", 1'b0, 1'b1, na);
    @(negedge clk);
    check_state("idle", 1'b0, 1'b0, na);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; cfg_pattern = 4'd0;
    cfg_overlap = 1'b0; cfg_window = 8'd0; din = 1'b0; din_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_state("reset", 1'b0, 1'b0, 0);
    chk_match("reset", 1'b0);
    reset = 1'b1;

    load_stream10();
    do_scan(4'b1011, 1'b1, 10, 1'b0, -1, 1'b0, 1'b0);
    do_scan(4'b1011, 1'b0, 10, 1'b0, -1, 1'b0, 1'b0);
    do_scan(4'b1011, 1'b1, 10, 1'b1, -1, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) sbits[i] = 1'b1;
    do_scan(4'b1111, 1'b1, 8, 1'b0, -1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_state("sat_hold", 1'b0, 1'b0, 5);

    do_scan(4'b1111, 1'b1, 0, 1'b0, -1, 1'b0, 1'b1);

    load_stream10();
    do_scan(4'b1011, 1'b1, 10, 1'b0, 6, 1'b0, 1'b0);

    // Reset mid-scan, then a clean rescan.
    @(negedge clk);
    cfg_pattern = 4'b1011; cfg_overlap = 1'b1; cfg_window = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      din = sbits[k]; din_valid = 1'b1;
      @(negedge clk);
    end
    check_state("pre_rst", 1'b1, 1'b0, 2);
    din = 1'b1;
    #2 reset = 1'b0;
    #1 check_state("async_rst", 1'b0, 1'b0, 0);
    chk_match("async_rst", 1'b0);
    @(negedge clk);
    reset = 1'b1; din_valid = 1'b0;
    @(negedge clk);
    check_state("post_rst", 1'b0, 1'b0, 0);
    do_scan(4'b1011, 1'b1, 10, 1'b0, -1, 1'b0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      int w;
      w = $urandom_range(0, 24);
      for (int i = 0; i < 32; i++) sbits[i] = 1'($urandom);
      do_scan(4'($urandom), 1'($urandom), w, 1'($urandom), ($urandom_range(0, 3) == 0) ?
              int'($urandom_range(0, 24)) : -1, 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
